// File: rtl/blake2_ctrl_pkg.sv
// Shared types and sizing helpers for the BLAKE2 message controller.
package blake2_ctrl_pkg;

    localparam int BUS_WIDTH_DEF   = 32;
    localparam int BLOCK_WIDTH_DEF = 1024;
    localparam int DATA_LENGTH_DEF = 128;

    localparam int WORDS_PER_BLOCK = BLOCK_WIDTH_DEF / BUS_WIDTH_DEF;
    localparam int BYTES_PER_WORD  = BUS_WIDTH_DEF / 8;
    localparam int IDX_WIDTH       = $clog2(WORDS_PER_BLOCK);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        FULL,
        NEXT,
        FINAL,
        WAIT_DIGEST
    } state_t;

    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

    function automatic int cnt_width(input int bytes);
        return $clog2(bytes + 1);
    endfunction

endpackage

// File: rtl/blake2_keep_count.sv
// Byte-enable helper: number of enabled bytes and the matching bit mask.
module blake2_keep_count
    import blake2_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    localparam int BYTES = BUS_WIDTH / 8,
    localparam int CW = cnt_width(BYTES)
) (
    input  logic [BYTES-1:0]     keep,
    output logic [CW-1:0]        count,
    output logic [BUS_WIDTH-1:0] mask
);

    always_comb begin
        count = '0;
        mask  = '0;
        for (int i = 0; i < BYTES; i++) begin
            count = count + CW'(keep[i]);
            mask[i*8 +: 8] = {8{keep[i]}};
        end
    end

endmodule

// File: rtl/blake2_msg_ctrl.sv
// Packs a byte stream into BLAKE2 message blocks and sequences init/next/final.
// The final command port is final_cmd because "final" is a reserved word.
module blake2_msg_ctrl
    import blake2_ctrl_pkg::*;
#(
    parameter int BUS_WIDTH   = BUS_WIDTH_DEF,
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int DATA_LENGTH = DATA_LENGTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BUS_WIDTH-1:0]   din,
    input  logic [BUS_WIDTH/8-1:0] din_keep,
    input  logic                   valid_in,
    input  logic                   last_in,
    output logic                   ready_out,
    input  logic                   hash_ready,
    input  logic                   digest_valid,
    output logic                   init,
    output logic                   next,
    output logic                   final_cmd,
    output logic [BLOCK_WIDTH-1:0] block,
    output logic [DATA_LENGTH-1:0] data_length
);

    localparam int WORDS = BLOCK_WIDTH / BUS_WIDTH;
    localparam int BYTES = BUS_WIDTH / 8;
    localparam int IW    = idx_width(WORDS);
    localparam int CW    = cnt_width(BYTES);

    state_t               state;
    logic [IW-1:0]        idx;
    logic                 blank;
    logic [CW-1:0]        cnt;
    logic [BUS_WIDTH-1:0] mask;
    logic                 keep_zero;
    logic                 accept;
    logic                 cmd_ok;
    logic                 slot_last;

    blake2_keep_count #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_keep (
        .keep  (din_keep),
        .count (cnt),
        .mask  (mask)
    );

    assign keep_zero = (din_keep == '0);
    assign slot_last = (idx == IW'(WORDS - 1));

    // A zero-byte closing beat is taken in FULL so a full last block stays final.
    assign ready_out = (state == FILL) ||
                       (state == FULL && valid_in && last_in && keep_zero);
    assign accept    = valid_in && ready_out;

    // hash_ready is ignored during and one cycle after any command pulse.
    assign cmd_ok = hash_ready && !blank && !init && !next && !final_cmd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            blank       <= 1'b0;
            init        <= 1'b0;
            next        <= 1'b0;
            final_cmd   <= 1'b0;
            block       <= '0;
            data_length <= '0;
        end else begin
            init      <= 1'b0;
            next      <= 1'b0;
            final_cmd <= 1'b0;
            blank     <= init || next || final_cmd;
            unique case (state)
                IDLE: begin
                    if (valid_in && cmd_ok) begin
                        init        <= 1'b1;
                        block       <= '0;
                        data_length <= '0;
                        idx         <= '0;
                        state       <= FILL;
                    end
                end
                FILL: begin
                    if (accept) begin
                        for (int k = 0; k < WORDS; k++) begin
                            if (idx == IW'(k)) begin
                                block[k*BUS_WIDTH +: BUS_WIDTH] <= din & mask;
                            end
                        end
                        data_length <= data_length + DATA_LENGTH'(cnt);
                        idx         <= slot_last ? '0 : idx + IW'(1);
                        if (last_in) begin
                            state <= FINAL;
                        end else if (slot_last) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (valid_in) begin
                        state <= accept ? FINAL : NEXT;
                    end
                end
                NEXT: begin
                    // Block is cleared only after the pulse cycle so the core sees it.
                    if (next) begin
                        block <= '0;
                        idx   <= '0;
                        state <= FILL;
                    end else if (cmd_ok) begin
                        next <= 1'b1;
                    end
                end
                FINAL: begin
                    if (cmd_ok) begin
                        final_cmd <= 1'b1;
                        state     <= WAIT_DIGEST;
                    end
                end
                WAIT_DIGEST: begin
                    if (digest_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_msg_ctrl.sv
// Self-checking bench for blake2_msg_ctrl with a byte-level message model.
module tb_blake2_msg_ctrl;

    typedef struct {
        int             kind;
        logic [1023:0]  blk;
        logic [127:0]   dl;
    } rec_t;

    logic           clk = 1'b0;
    logic           reset;
    logic [31:0]    din;
    logic [3:0]     din_keep;
    logic           valid_in;
    logic           last_in;
    logic           ready_out;
    logic           hash_ready;
    logic           digest_valid;
    logic           init;
    logic           next;
    logic           final_cmd;
    logic [1023:0]  block;
    logic [127:0]   data_length;

    int             n_assert = 0;
    int             n_fail = 0;
    int             n_digest = 0;
    int             busy;
    bit             fin_pend;
    bit             hold_low = 1'b0;
    logic [7:0]     msg[$];
    rec_t           recs[$];

    blake2_msg_ctrl #(
        .BUS_WIDTH   (32),
        .BLOCK_WIDTH (1024),
        .DATA_LENGTH (128)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .din          (din),
        .din_keep     (din_keep),
        .valid_in     (valid_in),
        .last_in      (last_in),
        .ready_out    (ready_out),
        .hash_ready   (hash_ready),
        .digest_valid (digest_valid),
        .init         (init),
        .next         (next),
        .final_cmd    (final_cmd),
        .block        (block),
        .data_length  (data_length)
    );

    always #5 clk = ~clk;

    // Core model: busy for a few cycles after each command, digest after final.
    initial begin
        hash_ready   = 1'b0;
        digest_valid = 1'b0;
        busy         = 0;
        fin_pend     = 1'b0;
        forever begin
            @(negedge clk);
            digest_valid = 1'b0;
            if (reset) begin
                busy       = 0;
                fin_pend   = 1'b0;
                hash_ready = 1'b0;
            end else if (init || next || final_cmd) begin
                busy       = $urandom_range(1, 4);
                fin_pend   = fin_pend || (final_cmd === 1'b1);
                hash_ready = 1'b0;
            end else if (busy > 0) begin
                busy--;
                hash_ready = 1'b0;
                if (busy == 0 && fin_pend) begin
                    digest_valid = 1'b1;
                    fin_pend     = 1'b0;
                    n_digest++;
                end
            end else begin
                hash_ready = !hold_low;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (init)
                    recs.push_back('{kind: 0, blk: '0, dl: '0});
                if (next)
                    recs.push_back('{kind: 1, blk: block, dl: data_length});
                if (final_cmd)
                    recs.push_back('{kind: 2, blk: block, dl: data_length});
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [1023:0] obs,
                           input logic [1023:0] exp);
        int w;
        w = 0;
        n_assert++;
        assert (obs === exp) else begin
            for (int k = 31; k >= 0; k--)
                if (obs[k*32 +: 32] !== exp[k*32 +: 32]) w = k;
            n_fail++;
            $error("FAIL %s: word %0d observed %h expected %h",
                   tag, w, obs[w*32 +: 32], exp[w*32 +: 32]);
        end
    endtask

    function automatic logic [1023:0] exp_block(input int b);
        logic [1023:0] e;
        int            pos;
        e = '0;
        for (int j = 0; j < 128; j++) begin
            pos = b * 128 + j;
            if (pos < msg.size()) e[j*8 +: 8] = msg[pos];
        end
        return e;
    endfunction

    // Called in the drive phase (1 time unit after a falling edge).
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k,
                             input bit l);
        bit         acc;
        logic [3:0] kp1;
        acc = 1'b0;
        kp1 = k + 4'd1;
        n_assert++;
        assert (((k & kp1) == 4'd0) && (k == 4'hF || l)) else begin
            n_fail++;
            $error("FAIL keep_legal: observed %b expected contiguous", k);
        end
        din      = d;
        din_keep = k;
        last_in  = l;
        valid_in = 1'b1;
        for (int c = 0; c < 300 && !acc; c++) begin
            #1;
            acc = (ready_out === 1'b1);
            @(negedge clk);
            #1;
        end
        chk("beat_accept", 128'(acc), 128'(1));
    endtask

    task automatic hold_check();
        @(negedge clk);
        #2;
        for (int c = 0; c < 20; c++) begin
            chk("hold_ready", 128'(ready_out), 128'(0));
            chk("hold_next", 128'(next), 128'(0));
            chk_blk("hold_block", block, exp_block(0));
            chk("hold_len", data_length, 128'(128));
            @(negedge clk);
            #2;
        end
        hold_low = 1'b0;
    endtask

    task automatic send_msg(input bit ez, input bit hold, input bit gaps);
        int         len;
        int         nb;
        logic [31:0] d;
        logic [3:0]  k;
        bit          l;
        len = msg.size();
        nb  = (len + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            d = $urandom;
            k = '0;
            for (int j = 0; j < 4; j++) begin
                if (4 * i + j < len) begin
                    d[j*8 +: 8] = msg[4*i+j];
                    k[j] = 1'b1;
                end
            end
            l = (i == nb - 1) && !ez;
            if (gaps && $urandom_range(0, 3) == 0) begin
                valid_in = 1'b0;
                @(negedge clk);
                #1;
            end
            if (hold && i == 31) hold_low = 1'b1;
            if (hold && i == 32) begin
                fork
                    send_beat(d, k, l);
                    hold_check();
                join
            end else begin
                send_beat(d, k, l);
            end
        end
        if (ez || len == 0) send_beat($urandom, 4'h0, 1'b1);
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        for (int c = 0; c < 2000 && n_digest == d0; c++) @(negedge clk);
        chk("msg_done", 128'(n_digest > d0), 128'(1));
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_msg(input string tag);
        int len;
        int nblk;
        int last;
        len  = msg.size();
        nblk = (len == 0) ? 1 : (len + 127) / 128;
        chk({tag, "_npulse"}, 128'(recs.size()), 128'(nblk + 1));
        if (recs.size() > 0) chk({tag, "_init"}, 128'(recs[0].kind), 128'(0));
        for (int b = 0; b < nblk; b++) begin
            if (b + 1 < recs.size()) begin
                last = (b == nblk - 1) ? 1 : 0;
                chk($sformatf("%s_b%0d_kind", tag, b),
                    128'(recs[b+1].kind), 128'(last ? 2 : 1));
                chk($sformatf("%s_b%0d_len", tag, b), recs[b+1].dl,
                    128'(last ? len : 128 * (b + 1)));
                chk_blk($sformatf("%s_b%0d_blk", tag, b),
                        recs[b+1].blk, exp_block(b));
            end
        end
        recs.delete();
    endtask

    task automatic run_msg(input string tag, input int len, input bit ez,
                           input bit hold, input bit gaps, input bit ones);
        int d0;
        d0 = n_digest;
        msg.delete();
        for (int i = 0; i < len; i++)
            msg.push_back(ones ? 8'h11 : 8'($urandom));
        recs.delete();
        send_msg(ez, hold, gaps);
        wait_done(d0);
        check_msg(tag);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, 128'(ready_out), 128'(0));
        chk({tag, "_init"}, 128'(init), 128'(0));
        chk({tag, "_next"}, 128'(next), 128'(0));
        chk({tag, "_final"}, 128'(final_cmd), 128'(0));
        chk_blk({tag, "_block"}, block, '0);
        chk({tag, "_len"}, data_length, 128'(0));
    endtask

    initial begin
        int len;
        bit ez;
        reset    = 1'b1;
        valid_in = 1'b0;
        last_in  = 1'b0;
        din      = '0;
        din_keep = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_reset_outs("rst");
        reset = 1'b0;
        @(negedge clk);
        #1;

        run_msg("empty", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_msg("one_word", 4, 1'b0, 1'b0, 1'b0, 1'b1);
        run_msg("b124", 124, 1'b0, 1'b0, 1'b1, 1'b0);
        run_msg("b128z", 128, 1'b1, 1'b0, 1'b1, 1'b0);
        run_msg("b132hold", 132, 1'b0, 1'b1, 1'b0, 1'b0);
        run_msg("b10", 10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Abort a message partway through filling its first block.
        recs.delete();
        for (int i = 0; i < 3; i++) send_beat($urandom, 4'hF, 1'b0);
        chk("abort_len_before", data_length, 128'(12));
        valid_in = 1'b0;
        reset    = 1'b1;
        #1;
        chk_reset_outs("abort");
        @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort_pulses", 128'(recs.size()), 128'(1));
        run_msg("after_abort", 40, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 300);
            ez  = (len % 4 == 0) && ($urandom_range(0, 1) == 1);
            run_msg($sformatf("rand%0d", r), len, ez, 1'b0, 1'b1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
